key_remap_table: RTL

//   Parametrised user key-to-note remapper for the piano. In LEARN the player steps through

---
 rtl/key_remap_table.sv | 130 +++++++++++++
 1 files changed

// File: rtl/key_remap_table.sv
// Learnable key-to-note remapper: LEARN binds note codes 1..NUM_KEYS to keys on debounced
// pick presses; PLAY translates a single pressed key through the table into a note code.
module key_remap_table #(
    parameter int unsigned NUM_KEYS = 7,
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                pick,
    input  logic                relearn,
    output logic [NOTE_W-1:0]   note_out,
    output logic                learning,
    output logic [NOTE_W-1:0]   learn_idx,
    output logic                bind_ack
);

    localparam int unsigned KIDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        S_LEARN = 1'b0,
        S_PLAY  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   idx_q, idx_d;
    logic [NOTE_W-1:0]   map_q [NUM_KEYS];
    logic [NOTE_W-1:0]   map_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pick_s_q, pick_s_d;
    logic                pick_p_q, pick_p_d;
    logic [NOTE_W-1:0]   note_out_q, note_out_d;
    logic                learning_q, learning_d;
    logic [NOTE_W-1:0]   learn_idx_q, learn_idx_d;
    logic                bind_ack_q, bind_ack_d;

    logic                tick;
    logic                pick_edge;
    logic                onehot;
    logic [KIDX_W-1:0]   kidx;
    logic [NUM_KEYS-1:0] keys_m1;

    // Single-key decode: exactly one bit set, and its position.
    always_comb begin
        keys_m1 = keys - NUM_KEYS'(1);
        onehot  = (|keys) && !(|(keys & keys_m1));
        kidx    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) kidx = KIDX_W'(i);
        end
    end

    assign tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign pick_edge = tick & pick_s_q & ~pick_p_q;

    // Next-state, table update and registered outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        map_d      = map_q;
        cnt_d      = cnt_q;
        pick_s_d   = pick_s_q;
        pick_p_d   = pick_p_q;
        bind_ack_d = 1'b0;
        note_out_d = '0;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                pick_p_d = pick_s_q;
                pick_s_d = pick;
            end

            if (relearn) begin
                state_d = S_LEARN;
                idx_d   = NOTE_W'(1);
            end else if (state_q == S_LEARN && pick_edge && onehot) begin
                map_d[kidx] = idx_q;
                bind_ack_d  = 1'b1;
                if (idx_q == NOTE_W'(NUM_KEYS)) begin
                    state_d = S_PLAY;
                    idx_d   = NOTE_W'(1);
                end else begin
                    idx_d = idx_q + NOTE_W'(1);
                end
            end

            if (state_q == S_LEARN) note_out_d = idx_q;
            else if (onehot)        note_out_d = map_q[kidx];
        end

        learning_d  = (state_d == S_LEARN);
        learn_idx_d = learning_d ? idx_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LEARN;
            idx_q       <= NOTE_W'(1);
            cnt_q       <= '0;
            pick_s_q    <= 1'b0;
            pick_p_q    <= 1'b0;
            note_out_q  <= '0;
            learning_q  <= 1'b1;
            learn_idx_q <= NOTE_W'(1);
            bind_ack_q  <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) map_q[i] <= NOTE_W'(i + 1);
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pick_s_q    <= pick_s_d;
            pick_p_q    <= pick_p_d;
            note_out_q  <= note_out_d;
            learning_q  <= learning_d;
            learn_idx_q <= learn_idx_d;
            bind_ack_q  <= bind_ack_d;
            for (int i = 0; i < NUM_KEYS; i++) map_q[i] <= map_d[i];
        end
    end

    assign note_out  = note_out_q;
    assign learning  = learning_q;
    assign learn_idx = learn_idx_q;
    assign bind_ack  = bind_ack_q;

endmodule
